frac_reduce: RTL and testbench

- Reduces a fraction num/den to lowest terms.
- Acts as the sequencing stage around the subtractive GCD unit: loads it, waits for its result, then consumes that result.
- Divides both operands by the GCD with a shared-divisor restoring divider and presents the reduced pair on a valid/ready output.
- Sits between the operand source and any downstream arithmetic consumer.

---
 rtl/frac_reduce_if.sv | 26 ++
 rtl/frac_reduce.sv | 205 ++++++++++++++++++++
 tb/tb_frac_reduce.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/frac_reduce_if.sv
// Operand/result handshake bundle for the fraction reducer.
// The source side (master) presents num/den and accepts the reduced pair;
// the reducer (slave) answers with in_ready and the registered result.
interface frac_reduce_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] num;
    logic [W-1:0] den;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] num_r;
    logic [W-1:0] den_r;
    logic         err;

    modport master (
        output in_valid, num, den, out_ready,
        input  in_ready, out_valid, num_r, den_r, err
    );

    modport slave (
        input  in_valid, num, den, out_ready,
        output in_ready, out_valid, num_r, den_r, err
    );
endinterface

// File: rtl/frac_reduce.sv
// Fraction reducer: sequences an external subtractive GCD unit, then divides
// numerator and denominator by the GCD with two restoring dividers that share
// one divisor, and returns the reduced pair on a valid/ready handshake.
// 0/0 is short-circuited to an error result without touching the GCD unit.
module frac_reduce #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    frac_reduce_if.slave bus,
    output logic [W-1:0] gcd_a,
    output logic [W-1:0] gcd_b,
    output logic         gcd_ini,
    input  logic [W-1:0] gcd_s,
    input  logic         gcd_fin
);

    localparam int CW = $clog2(W);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_WAIT = 3'd2,
        ST_DIV  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // One restoring-division step: shift the next dividend bit into the
    // remainder, subtract the divisor when it fits, and shift the quotient
    // bit into the vacated low end of the dividend register.  Because the
    // remainder is always below the divisor, the difference fits in W bits.
    function automatic logic [2*W-1:0] div_step(
        input logic [W-1:0] rem,
        input logic [W-1:0] dvd,
        input logic [W-1:0] dsr
    );
        logic [W:0]   trial;
        logic [W-1:0] diff;
        trial = {rem, dvd[W-1]};
        diff  = trial[W-1:0] - dsr;
        if (trial >= {1'b0, dsr}) begin
            div_step = {diff, dvd[W-2:0], 1'b1};
        end else begin
            div_step = {trial[W-1:0], dvd[W-2:0], 1'b0};
        end
    endfunction

    state_t         state_q,     state_d;
    logic           in_ready_q,  in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   num_r_q,     num_r_d;
    logic [W-1:0]   den_r_q,     den_r_d;
    logic           err_q,       err_d;
    logic [W-1:0]   gcd_a_q,     gcd_a_d;
    logic [W-1:0]   gcd_b_q,     gcd_b_d;
    logic           gcd_ini_q,   gcd_ini_d;
    logic [W-1:0]   g_q,         g_d;
    logic [W-1:0]   rem_n_q,     rem_n_d;
    logic [W-1:0]   rem_d_q,     rem_d_d;
    logic [W-1:0]   dvd_n_q,     dvd_n_d;
    logic [W-1:0]   dvd_d_q,     dvd_d_d;
    logic [CW-1:0]  cnt_q,       cnt_d;

    logic [2*W-1:0] step_n_s;
    logic [2*W-1:0] step_d_s;

    assign step_n_s = div_step(rem_n_q, dvd_n_q, g_q);
    assign step_d_s = div_step(rem_d_q, dvd_d_q, g_q);

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.num_r     = num_r_q;
    assign bus.den_r     = den_r_q;
    assign bus.err       = err_q;
    assign gcd_a         = gcd_a_q;
    assign gcd_b         = gcd_b_q;
    assign gcd_ini       = gcd_ini_q;

    // Next-state and next-output logic for the sequencing FSM and datapath.
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        num_r_d     = num_r_q;
        den_r_d     = den_r_q;
        err_d       = err_q;
        gcd_a_d     = gcd_a_q;
        gcd_b_d     = gcd_b_q;
        gcd_ini_d   = 1'b0;
        g_d         = g_q;
        rem_n_d     = rem_n_q;
        rem_d_d     = rem_d_q;
        dvd_n_d     = dvd_n_q;
        dvd_d_d     = dvd_d_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    gcd_a_d    = bus.num;
                    gcd_b_d    = bus.den;
                    dvd_n_d    = bus.num;
                    dvd_d_d    = bus.den;
                    rem_n_d    = {W{1'b0}};
                    rem_d_d    = {W{1'b0}};
                    cnt_d      = {CW{1'b0}};
                    in_ready_d = 1'b0;
                    if ((bus.num == {W{1'b0}}) && (bus.den == {W{1'b0}})) begin
                        // 0/0 has no GCD; report it directly.
                        num_r_d     = {W{1'b0}};
                        den_r_d     = {W{1'b0}};
                        err_d       = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        gcd_ini_d = 1'b1;
                        state_d   = ST_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // gcd_fin still reflects the previous operation here.
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (gcd_fin) begin
                    g_d     = gcd_s;
                    state_d = ST_DIV;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DIV: begin
                rem_n_d = step_n_s[2*W-1:W];
                dvd_n_d = step_n_s[W-1:0];
                rem_d_d = step_d_s[2*W-1:W];
                dvd_d_d = step_d_s[W-1:0];
                cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == CW'(W - 1)) begin
                    num_r_d     = step_n_s[W-1:0];
                    den_r_d     = step_d_s[W-1:0];
                    err_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    state_d = ST_DIV;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            num_r_q     <= {W{1'b0}};
            den_r_q     <= {W{1'b0}};
            err_q       <= 1'b0;
            gcd_a_q     <= {W{1'b0}};
            gcd_b_q     <= {W{1'b0}};
            gcd_ini_q   <= 1'b0;
            g_q         <= {W{1'b0}};
            rem_n_q     <= {W{1'b0}};
            rem_d_q     <= {W{1'b0}};
            dvd_n_q     <= {W{1'b0}};
            dvd_d_q     <= {W{1'b0}};
            cnt_q       <= {CW{1'b0}};
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            num_r_q     <= num_r_d;
            den_r_q     <= den_r_d;
            err_q       <= err_d;
            gcd_a_q     <= gcd_a_d;
            gcd_b_q     <= gcd_b_d;
            gcd_ini_q   <= gcd_ini_d;
            g_q         <= g_d;
            rem_n_q     <= rem_n_d;
            rem_d_q     <= rem_d_d;
            dvd_n_q     <= dvd_n_d;
            dvd_d_q     <= dvd_d_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_frac_reduce.sv
// Bench for frac_reduce: a behavioural subtractive GCD unit is attached,
// directed vectors push hand-computed results into a scoreboard queue and a
// negedge monitor pops and compares on every output handshake.
module tb_frac_reduce;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frac_reduce_if #(.W(W)) ifc ();

    logic [W-1:0] gcd_a, gcd_b, gcd_s;
    logic         gcd_ini, gcd_fin;

    frac_reduce #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (ifc.slave),
        .gcd_a   (gcd_a),
        .gcd_b   (gcd_b),
        .gcd_ini (gcd_ini),
        .gcd_s   (gcd_s),
        .gcd_fin (gcd_fin)
    );

    // Subtractive GCD unit model (no reset, reloaded by gcd_ini).
    logic [W-1:0] ga = '0;
    logic [W-1:0] gb = '0;
    assign gcd_fin = (ga == gb) || (ga == '0) || (gb == '0);
    assign gcd_s   = (ga == '0) ? gb : ga;
    always @(posedge clk) begin
        if (gcd_ini) begin
            ga <= gcd_a;
            gb <= gcd_b;
        end else if (!gcd_fin) begin
            if (ga > gb) ga <= ga - gb;
            else         gb <= gb - ga;
        end
    end

    typedef struct {
        logic [W-1:0] n;
        logic [W-1:0] d;
        logic         e;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare the result on every accepted output.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ifc.out_valid && ifc.out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_output", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("num_r", {16'd0, ifc.num_r}, {16'd0, e.n});
                check("den_r", {16'd0, ifc.den_r}, {16'd0, e.d});
                check("err",   {31'd0, ifc.err},   {31'd0, e.e});
            end
        end
    end

    // Issue one operation; exp_lat < 0 skips the latency check.
    task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] d,
                          input logic [W-1:0] en, input logic [W-1:0] ed, input logic ee,
                          input int exp_lat, input int exp_ini, input int stall, input string tag);
        int lat, inis, rdy_hi, unstable;
        bit seen;
        exp_t e;
        @(posedge clk); #1;
        ifc.in_valid = 1'b1;
        ifc.num      = n;
        ifc.den      = d;
        e.n = en; e.d = ed; e.e = ee;
        sb_q.push_back(e);
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        lat = 0; inis = 0; rdy_hi = 0; seen = 1'b0;
        while (!seen && lat < 70000) begin
            @(negedge clk);
            lat++;
            if (ifc.in_ready) rdy_hi++;
            if (ifc.out_valid) seen = 1'b1;
            else if (gcd_ini) inis++;
        end
        if (!seen) begin
            check($sformatf("%s_timeout", tag), 32'd0, 32'd1);
            return;
        end
        if (exp_lat >= 0) check($sformatf("%s_latency", tag), lat, exp_lat);
        check($sformatf("%s_gcd_ini_pulses", tag), inis, exp_ini);
        check($sformatf("%s_in_ready_busy", tag), rdy_hi, 32'd0);
        if (stall > 0) begin
            unstable = 0;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                if (!ifc.out_valid || ifc.num_r !== en || ifc.den_r !== ed ||
                    ifc.err !== ee || ifc.in_ready !== 1'b0) unstable++;
            end
            check($sformatf("%s_stall_stable", tag), unstable, 32'd0);
        end
        @(posedge clk); #1;
        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        ifc.out_ready = 1'b0;
        @(negedge clk);
        check($sformatf("%s_valid_drop", tag), {31'd0, ifc.out_valid}, 32'd0);
        check($sformatf("%s_ready_rise", tag), {31'd0, ifc.in_ready}, 32'd1);
    endtask

    initial begin
        rst           = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.num       = '0;
        ifc.den       = '0;
        ifc.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  {31'd0, ifc.in_ready},  32'd1);
        check("rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
        check("rst_gcd_ini",   {31'd0, gcd_ini},       32'd0);
        check("rst_gcd_a",     {16'd0, gcd_a},         32'd0);
        check("rst_num_r",     {16'd0, ifc.num_r},     32'd0);
        check("rst_err",       {31'd0, ifc.err},       32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        //      n       d      en      ed     ee  lat    ini stall
        run_op(16'd12,  16'd18, 16'd2,  16'd3, 1'b0, 21,    1, 0,  "12_18");
        run_op(16'd17,  16'd5,  16'd17, 16'd5, 1'b0, 25,    1, 0,  "17_5");
        run_op(16'd0,   16'd7,  16'd0,  16'd1, 1'b0, 19,    1, 0,  "0_7");
        run_op(16'd9,   16'd0,  16'd1,  16'd0, 1'b0, 19,    1, 0,  "9_0");
        run_op(16'd0,   16'd0,  16'd0,  16'd0, 1'b1, 1,     0, 0,  "0_0");
        run_op(16'hFFFF,16'd1,  16'hFFFF,16'd1,1'b0, 65553, 1, 0,  "65535_1");
        run_op(16'd48,  16'd36, 16'd4,  16'd3, 1'b0, 22,    1, 10, "48_36");

        // Reset in the middle of the divide phase.
        @(posedge clk); #1;
        ifc.in_valid = 1'b1;
        ifc.num      = 16'd12;
        ifc.den      = 16'd18;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
        check("midrst_in_ready",  {31'd0, ifc.in_ready},  32'd1);
        check("midrst_num_r",     {16'd0, ifc.num_r},     32'd0);
        check("midrst_gcd_ini",   {31'd0, gcd_ini},       32'd0);
        run_op(16'd8,   16'd12, 16'd2,  16'd3, 1'b0, 21,    1, 0,  "8_12");

        repeat (3) @(posedge clk);
        check("sb_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
